// File: rtl/pattern_seq.sv
// Pattern buffer sequencer: steps fieldp from 0 to a captured last index, registering each byte for 1+dwell cycles.
// Optional macro PATSEQ_PINGPONG_EN adds a pingpong input for up/down looped playback.
module pattern_seq #(
  parameter int BUF_WIDTH = 8,
  parameter int BUF_SIZE  = 32,
  parameter int PTR_W     = 5,
  parameter int DWELL_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 loop_en,
`ifdef PATSEQ_PINGPONG_EN
  input  logic                 pingpong,
`endif
  input  logic [PTR_W-1:0]     seq_len,
  input  logic [DWELL_W-1:0]   dwell,
  input  logic                 ssel,
  output logic [PTR_W-1:0]     fieldp,
  input  logic [BUF_WIDTH-1:0] field_byte,
  output logic [BUF_WIDTH-1:0] pat_out,
  output logic                 pat_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0]   MAX_IDX   = PTR_W'(BUF_SIZE - 1);
  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  state_t             state;
  logic [PTR_W-1:0]   len_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt;

  logic               do_adv;
  logic               adv_finish;
  logic [PTR_W-1:0]   adv_ptr;
  logic [PTR_W-1:0]   len_clamped;

`ifdef PATSEQ_PINGPONG_EN
  logic               dir;
  logic               adv_dir;
`endif

  assign len_clamped = (seq_len > MAX_IDX) ? MAX_IDX : seq_len;

  // A step ends on the fetch itself when dwell is zero, otherwise on the last hold cycle.
  always_comb begin
    do_adv = ((state == FETCH) && (dwell_q == '0)) ||
             ((state == HOLD) && (cnt == DWELL_ONE));
  end

  // Next pointer after the current step; adv_finish means the run ends here.
  always_comb begin
    adv_finish = 1'b0;
    adv_ptr    = fieldp;
`ifdef PATSEQ_PINGPONG_EN
    adv_dir    = dir;
    if (dir) begin
      if (fieldp != '0) begin
        adv_ptr = fieldp - PTR_ONE;
      end else begin
        adv_dir = 1'b0;
        adv_ptr = (len_q == '0) ? '0 : PTR_ONE;
      end
    end else if (fieldp != len_q) begin
      adv_ptr = fieldp + PTR_ONE;
    end else if (!loop_en) begin
      adv_finish = 1'b1;
    end else if (pingpong && (len_q != '0)) begin
      adv_dir = 1'b1;
      adv_ptr = len_q - PTR_ONE;
    end else begin
      adv_ptr = '0;
    end
`else
    if (fieldp != len_q) begin
      adv_ptr = fieldp + PTR_ONE;
    end else if (!loop_en) begin
      adv_finish = 1'b1;
    end else begin
      adv_ptr = '0;
    end
`endif
  end

  // Abort paths (ssel before stop) leave pat_out and fieldp untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      fieldp    <= '0;
      pat_out   <= '0;
      pat_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      len_q     <= '0;
      dwell_q   <= '0;
      cnt       <= '0;
`ifdef PATSEQ_PINGPONG_EN
      dir       <= 1'b0;
`endif
    end else begin
      pat_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop && !ssel) begin
            len_q   <= len_clamped;
            dwell_q <= dwell;
            fieldp  <= '0;
            err     <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b1;
`ifdef PATSEQ_PINGPONG_EN
            dir     <= 1'b0;
`endif
            state   <= FETCH;
          end
        end
        FETCH, HOLD: begin
          if (ssel) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end else if (stop) begin
            busy  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            if (state == FETCH) begin
              pat_out   <= field_byte;
              pat_valid <= 1'b1;
            end
            if (do_adv) begin
              cnt <= '0;
              if (adv_finish) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                fieldp <= adv_ptr;
`ifdef PATSEQ_PINGPONG_EN
                dir    <= adv_dir;
`endif
                state  <= FETCH;
              end
            end else if (state == FETCH) begin
              cnt   <= dwell_q;
              state <= HOLD;
            end else begin
              cnt <= cnt - DWELL_ONE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_seq.sv
// Scoreboard bench for pattern_seq: stimulus pushes expected bytes and step spacing, a negedge monitor pops on pat_valid.
// Exercises the PATSEQ_PINGPONG_EN sequence when that macro is defined.
module tb_pattern_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop_en = 1'b0;
`ifdef PATSEQ_PINGPONG_EN
  logic       pingpong = 1'b0;
`endif
  logic [4:0] seq_len = '0;
  logic [7:0] dwell = '0;
  logic       ssel = 1'b0;
  logic [4:0] fieldp;
  logic [7:0] field_byte;
  logic [7:0] pat_out;
  logic       pat_valid;
  logic       busy;
  logic       done;
  logic       err;

  logic [7:0] buf_mem [32];
  assign field_byte = buf_mem[fieldp];

  pattern_seq dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .loop_en(loop_en),
`ifdef PATSEQ_PINGPONG_EN
    .pingpong(pingpong),
`endif
    .seq_len(seq_len),
    .dwell(dwell),
    .ssel(ssel),
    .fieldp(fieldp),
    .field_byte(field_byte),
    .pat_out(pat_out),
    .pat_valid(pat_valid),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] val;
    int         gap;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   last_valid = 0;
  exp_t mon_e;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic [7:0] val, input int gap);
    exp_t e;
    e.val = val;
    e.gap = gap;
    sb.push_back(e);
  endtask

  // Expected bytes are popped in order; gap is the cycle distance from the previous pulse (-1 = first of run).
  always @(negedge clk) begin
    if (!rst && pat_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_valid got %0h expected none", pat_out);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("pat_out", int'(pat_out), int'(mon_e.val));
        if (mon_e.gap >= 0) checkOutput("valid_gap", cyc - last_valid, mon_e.gap);
      end
      last_valid = cyc;
    end
  end

  task automatic applyStimulus(input logic [4:0] len, input logic [7:0] dw, input logic lp, output int t0);
    @(negedge clk);
    seq_len = len;
    dwell   = dw;
    loop_en = lp;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    t0      = cyc;
  endtask

  task automatic waitDone(input int budget, output int at);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) checkOutput("done_timeout", 0, 1);
    at = cyc;
  endtask

  int t0;
  int td;

  initial begin
    for (int i = 0; i < 32; i++) buf_mem[i] = 8'hA0 + 8'(i);
    buf_mem[0] = 8'h11;
    buf_mem[1] = 8'h22;
    buf_mem[2] = 8'h33;
    buf_mem[3] = 8'h44;

    repeat (2) @(negedge clk);
    checkOutput("rst_pat_out", int'(pat_out), 0);
    checkOutput("rst_fieldp", int'(fieldp), 0);
    checkOutput("rst_flags", int'({pat_valid, busy, done, err}), 0);
    rst = 1'b0;

    $display("[TB] single shot, dwell 0");
    pushExp(8'h11, -1); pushExp(8'h22, 1); pushExp(8'h33, 1); pushExp(8'h44, 1);
    applyStimulus(5'd3, 8'd0, 1'b0, t0);
    checkOutput("busy_after_start", int'(busy), 1);
    waitDone(40, td);
    checkOutput("done_cycle_d0", td - t0, 4);
    checkOutput("fieldp_at_done", int'(fieldp), 3);
    @(negedge clk);
    checkOutput("busy_after_done", int'(busy), 0);
    checkOutput("done_one_cycle", int'(done), 0);
    checkOutput("sb_empty_1", sb.size(), 0);

    $display("[TB] single shot, dwell 2");
    pushExp(8'h11, -1); pushExp(8'h22, 3); pushExp(8'h33, 3); pushExp(8'h44, 3);
    applyStimulus(5'd3, 8'd2, 1'b0, t0);
    waitDone(60, td);
    checkOutput("done_cycle_d2", td - t0, 12);
    @(negedge clk);
    checkOutput("sb_empty_2", sb.size(), 0);

    $display("[TB] looped seq_len 1, loop cleared at index 1");
    pushExp(8'h11, -1);
    for (int i = 0; i < 5; i++) pushExp((i % 2 == 0) ? 8'h22 : 8'h11, 1);
    applyStimulus(5'd1, 8'd0, 1'b1, t0);
    repeat (5) @(negedge clk);
    checkOutput("loop_fieldp", int'(fieldp), 1);
    loop_en = 1'b0;
    waitDone(40, td);
    checkOutput("loop_done_cycle", td - t0, 6);
    repeat (3) @(negedge clk);
    checkOutput("sb_empty_3", sb.size(), 0);

    $display("[TB] ssel abort during hold");
    pushExp(8'h11, -1); pushExp(8'h22, 6); pushExp(8'h33, 6);
    applyStimulus(5'd3, 8'd5, 1'b0, t0);
    repeat (15) @(negedge clk);
    ssel = 1'b1;
    @(negedge clk);
    checkOutput("ssel_err", int'(err), 1);
    checkOutput("ssel_busy", int'(busy), 0);
    checkOutput("ssel_pat_out", int'(pat_out), 8'h33);
    checkOutput("ssel_fieldp", int'(fieldp), 2);
    applyStimulus(5'd3, 8'd0, 1'b0, t0);
    repeat (2) @(negedge clk);
    checkOutput("start_ssel_ignored", int'(busy), 0);
    checkOutput("err_sticky", int'(err), 1);
    checkOutput("sb_empty_4", sb.size(), 0);
    ssel = 1'b0;

    $display("[TB] restart clears err, seq_len 0");
    pushExp(8'h11, -1);
    applyStimulus(5'd0, 8'd0, 1'b0, t0);
    checkOutput("err_cleared", int'(err), 0);
    waitDone(20, td);
    checkOutput("len0_done_cycle", td - t0, 1);
    checkOutput("len0_fieldp", int'(fieldp), 0);

    $display("[TB] stop with start in idle");
    stop = 1'b1;
    applyStimulus(5'd3, 8'd0, 1'b0, t0);
    repeat (3) @(negedge clk);
    checkOutput("stop_start_busy", int'(busy), 0);
    stop = 1'b0;

    $display("[TB] stop mid-run");
    pushExp(8'h11, -1); pushExp(8'h22, 3);
    applyStimulus(5'd3, 8'd2, 1'b0, t0);
    repeat (5) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checkOutput("stop_busy", int'(busy), 0);
    checkOutput("stop_done", int'(done), 0);
    checkOutput("stop_pat_out", int'(pat_out), 8'h22);
    checkOutput("stop_fieldp", int'(fieldp), 1);
    checkOutput("stop_err", int'(err), 0);

    $display("[TB] ssel and stop together");
    pushExp(8'h11, -1);
    applyStimulus(5'd3, 8'd3, 1'b0, t0);
    repeat (2) @(negedge clk);
    ssel = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    ssel = 1'b0;
    stop = 1'b0;
    checkOutput("ssel_stop_err", int'(err), 1);
    checkOutput("ssel_stop_busy", int'(busy), 0);

    $display("[TB] async reset mid-hold");
    pushExp(8'h11, -1);
    applyStimulus(5'd3, 8'd5, 1'b0, t0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("arst_pat_out", int'(pat_out), 0);
    checkOutput("arst_fieldp", int'(fieldp), 0);
    checkOutput("arst_flags", int'({pat_valid, busy, done, err}), 0);
    @(negedge clk);
    rst = 1'b0;

`ifdef PATSEQ_PINGPONG_EN
    $display("[TB] pingpong seq_len 3");
    pingpong = 1'b1;
    pushExp(8'h11, -1);
    pushExp(8'h22, 1); pushExp(8'h33, 1); pushExp(8'h44, 1); pushExp(8'h33, 1);
    pushExp(8'h22, 1); pushExp(8'h11, 1); pushExp(8'h22, 1); pushExp(8'h33, 1);
    pushExp(8'h44, 1);
    applyStimulus(5'd3, 8'd0, 1'b1, t0);
    repeat (8) @(negedge clk);
    loop_en = 1'b0;
    waitDone(40, td);
    checkOutput("pp_done_cycle", td - t0, 10);
    pingpong = 1'b0;
`endif

    repeat (3) @(negedge clk);
    checkOutput("sb_empty_final", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
